// File: rtl/periph_pkg.sv
// Peripheral register map, sequencer state encoding and bus request helpers
// shared by the burst sequencer and anything else talking to the GPIO/SPI block.
package periph_pkg;

    localparam logic [3:0] GPIO_DIR = 4'h0;
    localparam logic [3:0] GPIO_OUT = 4'h1;
    localparam logic [3:0] GPIO_IN  = 4'h2;
    localparam logic [3:0] SPI_DIV  = 4'h4;
    localparam logic [3:0] SPI_CS   = 4'h5;
    localparam logic [3:0] SPI_STAT = 4'h6;
    localparam logic [3:0] SPI_DATA = 4'h7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_DIV,
        ST_CS_LO,
        ST_WAIT_BYTE,
        ST_WR_DATA,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_CS_HI,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic       vld;
        logic       we;
        logic [3:0] addr;
        logic [7:0] dat;
    } bus_req_t;

    localparam bus_req_t BUS_IDLE = '{vld: 1'b0, we: 1'b0, addr: 4'h0, dat: 8'h00};

    function automatic bus_req_t bus_wr(input logic [3:0] addr, input logic [7:0] dat);
        bus_req_t r;
        r.vld  = 1'b1;
        r.we   = 1'b1;
        r.addr = addr;
        r.dat  = dat;
        return r;
    endfunction

    function automatic bus_req_t bus_rd(input logic [3:0] addr);
        bus_req_t r;
        r.vld  = 1'b1;
        r.we   = 1'b0;
        r.addr = addr;
        r.dat  = 8'h00;
        return r;
    endfunction

endpackage

// File: rtl/spi_burst_sequencer.sv
// Purpose: runs a whole SPI write burst on the peripheral bus (div, CS low, bytes, CS high).
// Latency: 4 cycles fixed overhead plus >=3 cycles per byte after its tx handshake.
// Backpressure: tx bytes taken only in WAIT_BYTE; CPU accesses stalled while a burst owns the bus.
module spi_burst_sequencer
    import periph_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             start_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [3:0]       div_in,
    input  logic             abort_in,
    input  logic [7:0]       tx_data_in,
    input  logic             tx_valid_in,
    output logic             tx_ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             aborted_out,
    input  logic [3:0]       cpu_addr_in,
    input  logic             cpu_addr_valid_in,
    input  logic             cpu_write_en_in,
    input  logic [7:0]       cpu_data_in,
    output logic             cpu_stall_out,
    output logic [3:0]       bus_addr_out,
    output logic             bus_addr_valid_out,
    output logic             bus_write_en_out,
    output logic [7:0]       bus_data_out,
    input  logic [7:0]       bus_data_in,
    input  logic             bus_data_valid_in
);

    localparam logic [LEN_W:0] FULL_BURST = {1'b1, {LEN_W{1'b0}}};

    seq_state_t     state;
    bus_req_t       seq_req;
    logic [LEN_W:0] remain;
    logic           done_q;
    logic           aborted_q;
    logic           abort_exit;

    // Only the SPI busy flag matters when polling status.
    logic unused_stat_bits;
    assign unused_stat_bits = ^bus_data_in[7:1];

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state      <= ST_IDLE;
            seq_req    <= BUS_IDLE;
            remain     <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            abort_exit <= 1'b0;
        end else begin
            seq_req <= BUS_IDLE;
            done_q  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        remain     <= (len_in == '0) ? FULL_BURST : {1'b0, len_in};
                        aborted_q  <= 1'b0;
                        abort_exit <= 1'b0;
                        seq_req    <= bus_wr(SPI_DIV, {4'h0, div_in});
                        state      <= ST_SET_DIV;
                    end
                end
                ST_SET_DIV: begin
                    seq_req <= bus_wr(SPI_CS, 8'h00);
                    state   <= ST_CS_LO;
                end
                ST_CS_LO: begin
                    state <= ST_WAIT_BYTE;
                end
                ST_WAIT_BYTE: begin
                    if (abort_in) begin
                        seq_req    <= bus_wr(SPI_CS, 8'h01);
                        abort_exit <= 1'b1;
                        state      <= ST_CS_HI;
                    end else if (tx_valid_in) begin
                        seq_req <= bus_wr(SPI_DATA, tx_data_in);
                        state   <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    remain  <= remain - 1'b1;
                    seq_req <= bus_rd(SPI_STAT);
                    state   <= ST_POLL_RD;
                end
                ST_POLL_RD: begin
                    state <= ST_POLL_WAIT;
                end
                ST_POLL_WAIT: begin
                    if (bus_data_valid_in) begin
                        if (bus_data_in[0]) begin
                            seq_req <= bus_rd(SPI_STAT);
                            state   <= ST_POLL_RD;
                        end else if (remain == '0 || abort_in) begin
                            // Abort only counts if bytes were left unsent.
                            seq_req    <= bus_wr(SPI_CS, 8'h01);
                            abort_exit <= (remain != '0);
                            state      <= ST_CS_HI;
                        end else begin
                            state <= ST_WAIT_BYTE;
                        end
                    end
                end
                ST_CS_HI: begin
                    done_q    <= 1'b1;
                    aborted_q <= abort_exit;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_out    = (state != ST_IDLE);
    assign done_out    = done_q;
    assign aborted_out = aborted_q;

    // Ready is masked by abort so a byte is never handshaken and then dropped.
    assign tx_ready_out = (state == ST_WAIT_BYTE) && !abort_in;

    assign cpu_stall_out      = busy_out && cpu_addr_valid_in;
    assign bus_addr_out       = busy_out ? seq_req.addr : cpu_addr_in;
    assign bus_addr_valid_out = busy_out ? seq_req.vld  : cpu_addr_valid_in;
    assign bus_write_en_out   = busy_out ? seq_req.we   : cpu_write_en_in;
    assign bus_data_out       = busy_out ? seq_req.dat  : cpu_data_in;

endmodule

// File: doc/spi_burst_sequencer.md
# spi_burst_sequencer

Bus master that runs a complete multi-byte SPI write burst on the memory-mapped peripheral register block (GPIO/SPI at 0xFx0y) without CPU involvement. It sets the divider, asserts CS, streams bytes from a valid/ready source, and waits for each byte by polling the SPI status register. It then releases CS and pulses done. It sits between the CPU memory bus and the peripheral register port, passing CPU accesses straight through when idle and stalling the CPU while a burst owns the bus.

## Interface
- LEN_W, 8, width of burst length; length 0 means 2^LEN_W bytes
- clk_in  in  1  single clock
- reset_n_in  in  1  asynchronous, active-low reset
- start_in  in  1  burst request pulse; sampled only in IDLE
- len_in  in  LEN_W  byte count, captured with start_in
- div_in  in  4  SPI divider value, captured with start_in
- abort_in  in  1  level; finish current byte, then release CS
- tx_data_in  in  8  next byte to send
- tx_valid_in  in  1  tx_data_in valid
- tx_ready_out  out  1  byte accepted when tx_valid_in && tx_ready_out
- busy_out  out  1  sequencer owns the peripheral bus
- done_out  out  1  one-cycle pulse at burst end
- aborted_out  out  1  registered; set with done_out if the burst ended via abort, cleared on next start
- cpu_addr_in  in  4  CPU peripheral address
- cpu_addr_valid_in  in  1  CPU access strobe
- cpu_write_en_in  in  1  CPU write enable
- cpu_data_in  in  8  CPU write data
- cpu_stall_out  out  1  CPU access not forwarded this cycle
- bus_addr_out  out  4  peripheral address
- bus_addr_valid_out  out  1  peripheral access strobe
- bus_write_en_out  out  1  peripheral write enable
- bus_data_out  out  8  peripheral write data
- bus_data_in  in  8  peripheral read data, valid one cycle after read strobe
- bus_data_valid_in  in  1  read data valid

## Operation
- Register map used: 0x4 divider, 0x5 CS (bit0, 1 = inactive), 0x6 status (bit0 = busy), 0x7 data.
- States: IDLE → SET_DIV → CS_LO → WAIT_BYTE → WR_DATA → POLL_RD → POLL_WAIT → (WAIT_BYTE | CS_HI) → DONE → IDLE.
- IDLE: bus outputs equal the CPU inputs combinationally. cpu_stall_out=0. start_in captures len, div, and clears aborted_out.
- SET_DIV: write 0x4 ← {4'h0,div}. CS_LO: write 0x5 ← 0x00.
- WAIT_BYTE: tx_ready_out=1, no bus access. On handshake, latch the byte and go to WR_DATA. If abort_in is set, go to CS_HI instead (no byte taken).
- WR_DATA: write 0x7 ← byte, decrement remaining count.
- POLL_RD: read 0x6 (one strobe). POLL_WAIT: wait for bus_data_valid_in.
  - bit0=1 → back to POLL_RD.
  - bit0=0 → CS_HI if count is 0 or abort_in is set, else WAIT_BYTE.
- CS_HI: write 0x5 ← 0x01. DONE: done_out=1 for one cycle, aborted_out updated.
- In all non-IDLE states, cpu_stall_out = cpu_addr_valid_in and CPU accesses are not forwarded. CPU must hold its request until unstalled.
- Remaining count is LEN_W+1 bits so len 0 loads 2^LEN_W.

## Timing
- Reset: state IDLE. tx_ready_out, busy_out, done_out, aborted_out = 0. Sequencer bus drive = 0; bus outputs follow the CPU inputs.
- Sequencer bus outputs are registered; each bus access is exactly one cycle of bus_addr_valid_out.
- start_in and a CPU access in the same IDLE cycle: the CPU access is forwarded that cycle. SET_DIV is issued on the next cycle.
- busy_out is high from the cycle after start acceptance through DONE inclusive.
- Minimum per byte, zero poll retries: WR_DATA, POLL_RD, POLL_WAIT = 3 cycles plus handshake.
- Fixed overhead: SET_DIV, CS_LO, CS_HI, DONE = 4 cycles.
- abort_in never cuts a byte mid-shift; CS always returns high before DONE.
- Reset asserted mid-burst returns to IDLE immediately. The peripheral's own reset restores CS high.
- tx_valid_in low in WAIT_BYTE: remain in WAIT_BYTE indefinitely, CS held low.

## Structure
- Shared package `periph_pkg`: register address constants (GPIO_DIR=0, GPIO_OUT=1, GPIO_IN=2, SPI_DIV=4, SPI_CS=5, SPI_STAT=6, SPI_DATA=7) and the sequencer state enum.
- Single module. The CPU/sequencer bus mux is inline, with no sub-module.

## Test plan
- Reset, then CPU write 0x1←0x3C while idle → forwarded the same cycle, stall=0, GPIO out reads back 0x3C.
- start, len=1, div=0, byte 0xA5, with the real peripheral attached:
  - bus writes 0x4←0x00, 0x5←0x00, 0x7←0xA5;
  - status polls until bit0=0, then 0x5←0x01;
  - MOSI shifts 1,0,1,0,0,1,0,1 on 8 SCLK rising edges; done pulse once.
- len=3, tx_valid delayed 20 cycles before the second byte → CS stays low through the gap; 3 data writes; done after the third poll clears.
- CPU read request issued during a burst → cpu_stall_out=1 until the cycle after DONE, then forwarded; no CPU strobe appears on the bus mid-burst.
- abort_in raised during the first byte's shift, len=4 → first byte completes, no further data writes, CS←1, done_out=1 with aborted_out=1.
- reset_n_in low mid-poll → outputs at reset values asynchronously; a fresh start afterward runs a full burst correctly.
